// File: rtl/glyph_row_streamer_pkg.sv
// Shared definitions for the glyph row streamer: FSM encodings, glyph geometry
// and the helper that extracts one pixel row from a packed 8x8 glyph.
package glyph_row_streamer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int GLYPH_W    = 8;
  localparam int GLYPH_ROWS = 8;

  // Row 0 is the top byte of the glyph word; bit 7 of the byte is the leftmost pixel.
  function automatic logic [GLYPH_W-1:0] glyph_row(input logic [63:0] g, input logic [2:0] r);
    return g[(GLYPH_ROWS - 1 - int'(r)) * GLYPH_W +: GLYPH_W];
  endfunction

endpackage

// File: rtl/ascciTo8x8.sv
// Combinational ASCII to 8x8 glyph lookup shared by the pixel streamers.
// Codes without a glyph render as a blank (space) cell.
module ascciTo8x8 (
  input  logic [7:0]  ascii,
  output logic [63:0] glyph
);

  always_comb begin
    glyph = 64'h0;
    case (ascii)
      8'h41:   glyph = 64'h183C66667E666600;  // A
      8'h42:   glyph = 64'h7C66667C66667C00;  // B
      8'h48:   glyph = 64'h6666667E66666600;  // H
      8'h30:   glyph = 64'h3C666E7666663C00;  // 0
      8'h31:   glyph = 64'h1838181818187E00;  // 1
      8'h2A:   glyph = 64'h00663CFF3C660000;  // *
      8'h23:   glyph = 64'h6C6CFE6CFE6C6C00;  // #
      default: glyph = 64'h0;
    endcase
  end

endmodule

// File: rtl/glyph_row_streamer.sv
// Streams one glyph row of a buffered text line as serial pixels with valid/ready.
// Optional build macro CURSOR_INVERT_EN adds cursor_pos and inverts that character cell.
//
// state   | meaning
// S_IDLE  | waiting for start, outputs quiet
// S_FETCH | read buffer[ci] into char_q
// S_LOAD  | load selected glyph row of char_q into shift register
// S_SHIFT | present pixels, shift on each handshake (8 per character)
// S_DONE  | one-cycle done pulse, back to idle
module glyph_row_streamer
  import glyph_row_streamer_pkg::*;
#(
  parameter int NCHARS = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  input  logic              start,
  input  logic [2:0]        row,
  output logic              busy,
  output logic              done,
  output logic              px_valid,
  output logic              px_data,
  output logic [ADDR_W-1:0] px_col,
  input  logic              px_ready
`ifdef CURSOR_INVERT_EN
  ,
  input  logic [ADDR_W-1:0] cursor_pos
`endif
);

  state_t              state_q, state_d;
  logic [7:0]          buffer [NCHARS];
  logic [2:0]          row_q;
  logic [ADDR_W-1:0]   ci_q;
  logic [7:0]          char_q;
  logic [GLYPH_W-1:0]  shreg_q;
  logic [2:0]          bitcnt_q;
  logic [63:0]         glyph;
  logic                last_char;
  logic                pix;
`ifdef CURSOR_INVERT_EN
  logic                cursor_hit_q;
`endif

  ascciTo8x8 u_ascii_to_8x8 (
    .ascii (char_q),
    .glyph (glyph)
  );

  assign last_char = (ci_q == ADDR_W'(NCHARS - 1));

`ifdef CURSOR_INVERT_EN
  assign pix = shreg_q[GLYPH_W-1] ^ cursor_hit_q;
`else
  assign pix = shreg_q[GLYPH_W-1];
`endif

  // Writes land in the same edge that FETCH samples, so FETCH sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCHARS; i++) buffer[i] <= ASCII_SPACE;
    end else if (wr_en && (int'(wr_addr) < NCHARS)) begin
      buffer[wr_addr] <= wr_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    done     = 1'b0;
    px_valid = 1'b0;
    px_data  = 1'b0;
    px_col   = '0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: begin
        px_valid = 1'b1;
        px_data  = pix;
        px_col   = ci_q;
        if (px_ready && (bitcnt_q == 3'd7)) state_d = last_char ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      ci_q         <= '0;
      char_q       <= ASCII_SPACE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
`ifdef CURSOR_INVERT_EN
      cursor_hit_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            row_q <= row;
            ci_q  <= '0;
          end
        end
        S_FETCH: char_q <= buffer[ci_q];
        S_LOAD: begin
          shreg_q      <= glyph_row(glyph, row_q);
          bitcnt_q     <= '0;
`ifdef CURSOR_INVERT_EN
          cursor_hit_q <= (cursor_pos == ci_q);
`endif
        end
        S_SHIFT: begin
          if (px_ready) begin
            shreg_q  <= {shreg_q[GLYPH_W-2:0], 1'b0};
            bitcnt_q <= bitcnt_q + 3'd1;
            if ((bitcnt_q == 3'd7) && !last_char) ci_q <= ci_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_glyph_row_streamer.sv
// Randomized bench for glyph_row_streamer against a line-level pixel model.
// Build with CURSOR_INVERT_EN defined to also cover the cursor inversion.
module tb_glyph_row_streamer;

  localparam int NCHARS = 16;
  localparam int ADDR_W = 4;
  localparam int NPIX   = NCHARS * 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_char;
  logic              start;
  logic [2:0]        row;
  logic              busy, done, px_valid, px_data, px_ready;
  logic [ADDR_W-1:0] px_col;
  logic [ADDR_W-1:0] cursor_pos;

  int checks = 0;
  int errors = 0;
  logic [7:0] model_buf [NCHARS];

`ifdef CURSOR_INVERT_EN
  localparam bit CUR_EN = 1'b1;
`else
  localparam bit CUR_EN = 1'b0;
`endif

  glyph_row_streamer #(.NCHARS(NCHARS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .start      (start),
    .row        (row),
    .busy       (busy),
    .done       (done),
    .px_valid   (px_valid),
    .px_data    (px_data),
    .px_col     (px_col),
    .px_ready   (px_ready)
`ifdef CURSOR_INVERT_EN
    ,
    .cursor_pos (cursor_pos)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] font(input logic [7:0] ch);
    logic [63:0] g;
    case (ch)
      8'h41:   g = 64'h183C66667E666600;
      8'h42:   g = 64'h7C66667C66667C00;
      8'h48:   g = 64'h6666667E66666600;
      8'h30:   g = 64'h3C666E7666663C00;
      8'h31:   g = 64'h1838181818187E00;
      8'h2A:   g = 64'h00663CFF3C660000;
      8'h23:   g = 64'h6C6CFE6CFE6C6C00;
      default: g = 64'h0;
    endcase
    return g;
  endfunction

  function automatic logic [7:0] rand_char();
    logic [7:0] c;
    case ($urandom_range(8))
      0: c = 8'h20;
      1: c = 8'h41;
      2: c = 8'h42;
      3: c = 8'h48;
      4: c = 8'h30;
      5: c = 8'h31;
      6: c = 8'h2A;
      7: c = 8'h7F;
      default: c = 8'hC3;
    endcase
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCHARS; i++) model_buf[i] = 8'h20;
  endtask

  task automatic write_char(input int addr, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = ADDR_W'(addr); wr_char = c;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model_buf[addr] = c;
  endtask

  // One line request. wr_cyc/restart_cyc/abort_cyc are cycle numbers after the
  // accepting edge (0 = unused); cycle 1 is the first cycle with busy high.
  task automatic run_line(input logic [2:0] r, input int ready_pct, input int wr_cyc,
                          input int wr_pos, input logic [7:0] wr_c,
                          input int restart_cyc, input int abort_cyc);
    logic [NPIX-1:0]        exp_px, got_px;
    logic [NPIX*ADDR_W-1:0] exp_cols, got_cols;
    logic [7:0]             byte_v;
    logic [63:0]            g;
    logic                   pv_prev, pr_prev, pd_prev;
    logic [ADDR_W-1:0]      pc_prev;
    int npx, cyc, first_cyc, ndone, done_cyc, c;

    for (int p = 0; p < NPIX; p++) begin
      c = p / 8;
      g = font(model_buf[c]);
      byte_v = 8'(g >> (8 * (7 - int'(r))));
      exp_px[p] = byte_v[7 - (p % 8)] ^ (CUR_EN && (c == int'(cursor_pos)));
      exp_cols[p*ADDR_W +: ADDR_W] = ADDR_W'(c);
    end
    got_px = '0; got_cols = '0;

    start = 1'b1; row = r;
    px_ready = ($urandom_range(99) < ready_pct);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; ndone = 0; npx = 0; first_cyc = 0; done_cyc = 0;
    pv_prev = 1'b0; pr_prev = 1'b0; pd_prev = 1'b0; pc_prev = '0;
    while (ndone == 0 && cyc < 4000) begin
      wr_en   = (cyc == wr_cyc);
      wr_addr = ADDR_W'(wr_pos);
      wr_char = wr_c;
      start   = (cyc == restart_cyc);
      row     = 3'(~r);
      px_ready = ($urandom_range(99) < ready_pct);
      @(negedge clk);
      if (cyc == abort_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 512'(px_valid), 512'(0));
        chk("abort_busy", 512'(busy), 512'(0));
        chk("abort_data_col", 512'({px_data, px_col}), 512'(0));
        @(posedge clk); #1;
        chk("abort_done", 512'(done), 512'(0));
        wr_en = 1'b0; start = 1'b0; px_ready = 1'b0;
        rst_n = 1'b1;
        model_reset();
        return;
      end
      chk("busy_in_line", 512'(busy), 512'(1));
      if (pv_prev && !pr_prev) begin
        chk("hold_valid", 512'(px_valid), 512'(1));
        chk("hold_data_col", 512'({px_data, px_col}), 512'({pd_prev, pc_prev}));
      end
      if (px_valid && px_ready) begin
        if (npx == 0) first_cyc = cyc;
        if (npx < NPIX) begin
          got_px[npx] = px_data;
          got_cols[npx*ADDR_W +: ADDR_W] = px_col;
        end
        npx++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      pv_prev = px_valid; pr_prev = px_ready; pd_prev = px_data; pc_prev = px_col;
      @(posedge clk); #1;
      cyc++;
    end
    wr_en = 1'b0; start = 1'b0;
    chk("done_seen", 512'(ndone), 512'(1));
    @(negedge clk);
    chk("idle_after_done", 512'({busy, done, px_valid}), 512'(0));
    @(posedge clk); #1;
    chk("pixel_count", 512'(npx), 512'(NPIX));
    chk("pixels", 512'(got_px), 512'(exp_px));
    chk("columns", got_cols, exp_cols);
    if (ready_pct == 100) begin
      chk("first_px_latency", 512'(first_cyc), 512'(3));
      chk("done_latency", 512'(done_cyc), 512'(NCHARS * 10 + 1));
    end
    if (wr_cyc > 0) model_buf[wr_pos] = wr_c;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_char = 8'h0;
    start = 1'b0; row = 3'd0; px_ready = 1'b0; cursor_pos = 4'd9;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_done", 512'({busy, done}), 512'(0));
    chk("reset_px", 512'({px_valid, px_data, px_col}), 512'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // cleared buffer renders blank
    run_line(3'($urandom_range(7)), 100, 0, 0, 8'h0, 0, 0);

    // single 'A' at column 0
    write_char(0, 8'h41);
    run_line(3'd0, 100, 0, 0, 8'h0, 0, 0);

    // same line under random backpressure
    run_line(3'd0, 40, 0, 0, 8'h0, 0, 0);

    // row 7 with a second start while busy
    run_line(3'd7, 100, 0, 0, 8'h0, 50, 0);

    // random lines
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < NCHARS; i++) write_char(i, rand_char());
      run_line(3'($urandom_range(7)), (n % 2 == 0) ? 100 : 60, 0, 0, 8'h0,
               ($urandom_range(1) == 1) ? 30 + n : 0, 0);
    end

    // write during FETCH of position 5: old char this line, new char next line
    write_char(5, 8'h41);
    run_line(3'd2, 100, 1 + 10 * 5, 5, 8'h42, 0, 0);
    run_line(3'd2, 100, 0, 0, 8'h0, 0, 0);

    // reset mid-SHIFT, then a full line from the cleared buffer
    run_line(3'd1, 100, 0, 0, 8'h0, 0, 37);
    write_char(3, 8'h48);
    run_line(3'd3, 70, 0, 0, 8'h0, 0, 0);

`ifdef CURSOR_INVERT_EN
    for (int i = 0; i < NCHARS; i++) write_char(i, 8'h20);
    cursor_pos = 4'd3;
    run_line(3'($urandom_range(7)), 100, 0, 0, 8'h0, 0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
